frame_burst_writer: RTL and testbench

Upstream-side memory writer for the PSRAM frame buffer. It consumes 32-bit pixel words (two RGB565 pixels each) from the camera load queue, a 1024-word ping-pong row RAM plus a command FIFO. It writes each row to PSRAM as fixed-length bursts through the shared 4-way arbiter (writer slot). It starts on a pulse from the video controller and reports completion with upload_done.

---
 rtl/camera_mem_pkg.sv | 28 ++
 rtl/frame_burst_writer.sv | 247 ++++++++++++++++++++++++
 tb/tb_frame_burst_writer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/camera_mem_pkg.sv
// Definitions shared between the camera-side load queue producer and the PSRAM frame writer.
package camera_mem_pkg;

    localparam int unsigned ADDR_W             = 21;
    localparam int unsigned DATA_W             = 32;
    localparam int unsigned PIX_ADDR_W         = 10;
    localparam int unsigned CMD_W              = 2;
    localparam int unsigned ROW_RAM_HALF_WORDS = 512;

    localparam int unsigned DEF_BURST_WORDS = 8;
    localparam int unsigned DEF_CMD_GAP     = 16;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP         = 2'd0,
        CMD_FRAME_START = 2'd1,
        CMD_ROW_READY   = 2'd2,
        CMD_FRAME_END   = 2'd3
    } load_cmd_e;

    // A row must fit one row-RAM half and split into whole bursts.
    function automatic bit frame_width_ok(input int unsigned frame_width,
                                          input int unsigned burst_words);
        return (burst_words != 0) &&
               ((frame_width / 2) <= ROW_RAM_HALF_WORDS) &&
               (((frame_width / 2) % burst_words) == 0);
    endfunction

endpackage

// File: rtl/frame_burst_writer.sv
// PSRAM frame writer: drains ping-pong row-RAM halves as fixed-length write bursts
// through the arbiter writer slot, paced by the camera load command queue.
module frame_burst_writer
    import camera_mem_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH  = 640,
    parameter int unsigned FRAME_HEIGHT = 480,
    parameter int unsigned MEMORY_BURST = 4 * DEF_BURST_WORDS,
    parameter int unsigned CMD_GAP      = DEF_CMD_GAP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic                  command_data_valid,
    input  logic [CMD_W-1:0]      command_data,
    output logic                  read_rdy,
    output logic                  mem_load_clk,
    output logic [PIX_ADDR_W-1:0] pixel_addr,
    input  logic [DATA_W-1:0]     pixel_data,
    output logic                  write_rq,
    input  logic                  write_ack,
    output logic                  mem_wr_en,
    output logic [ADDR_W-1:0]     write_addr,
    output logic [DATA_W-1:0]     write_data,
    output logic                  upload_done
);

    localparam int unsigned BURST_WORDS = MEMORY_BURST / 4;
    localparam int unsigned ROW_WORDS   = FRAME_WIDTH / 2;
    localparam int unsigned PTR_STEP    = MEMORY_BURST / 2;
    localparam int unsigned WORD_IDX_W  = PIX_ADDR_W - 1;
    localparam int unsigned WORD_W      = WORD_IDX_W + 1;
    localparam int unsigned ROW_W       = $clog2(FRAME_HEIGHT + 1);
    localparam int unsigned CNT_W       = $clog2(CMD_GAP + 3);

    if (!frame_width_ok(FRAME_WIDTH, BURST_WORDS) || (CMD_GAP < BURST_WORDS + 1)) begin : g_bad_cfg
        $error("frame_burst_writer: illegal FRAME_WIDTH / MEMORY_BURST / CMD_GAP combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CMD,
        ST_REQ,
        ST_PREFETCH,
        ST_BURST,
        ST_GAP,
        ST_ROW_END,
        ST_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [ADDR_W-1:0]     ptr_q, ptr_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic                  half_q, half_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  read_rdy_q, read_rdy_d;
    logic [PIX_ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
    logic                  write_rq_q, write_rq_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_W-1:0]     write_addr_q, write_addr_d;
    logic [DATA_W-1:0]     write_data_q, write_data_d;
    logic                  upload_done_q, upload_done_d;

    // cnt_q counts cycles from T1 (first row-RAM address) to the end of the command gap.
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        ptr_d         = ptr_q;
        word_d        = word_q;
        row_d         = row_q;
        half_d        = half_q;
        cnt_d         = cnt_q;
        read_rdy_d    = 1'b0;
        pixel_addr_d  = pixel_addr_q;
        write_rq_d    = 1'b0;
        mem_wr_en_d   = 1'b0;
        write_addr_d  = '0;
        write_data_d  = '0;
        upload_done_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    ptr_d   = base_addr;
                    state_d = ST_WAIT_CMD;
                end
            end
            ST_WAIT_CMD: begin
                // The head seen during a pop cycle is stale; wait for the FIFO to advance.
                if (command_data_valid && !read_rdy_q) begin
                    case (load_cmd_e'(command_data))
                        CMD_NOP: read_rdy_d = 1'b1;
                        CMD_FRAME_START: begin
                            read_rdy_d = 1'b1;
                            row_d      = '0;
                            half_d     = 1'b0;
                            ptr_d      = base_q;
                        end
                        CMD_ROW_READY: begin
                            if (row_q < ROW_W'(FRAME_HEIGHT)) begin
                                word_d     = '0;
                                write_rq_d = 1'b1;
                                state_d    = ST_REQ;
                            end else begin
                                read_rdy_d = 1'b1;
                            end
                        end
                        CMD_FRAME_END: begin
                            read_rdy_d = 1'b1;
                            state_d    = ST_DONE;
                        end
                    endcase
                end
            end
            ST_REQ: begin
                write_rq_d = 1'b1;
                if (write_ack) begin
                    pixel_addr_d = {half_q, word_q[WORD_IDX_W-1:0]};
                    cnt_d        = '0;
                    state_d      = ST_PREFETCH;
                end
            end
            ST_PREFETCH, ST_BURST: begin
                write_rq_d = 1'b1;
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q < CNT_W'(BURST_WORDS - 1)) begin
                    pixel_addr_d = {pixel_addr_q[PIX_ADDR_W-1],
                                    pixel_addr_q[WORD_IDX_W-1:0] + WORD_IDX_W'(1)};
                end
                if (state_q == ST_PREFETCH) begin
                    state_d = ST_BURST;
                end else begin
                    if (cnt_q <= CNT_W'(BURST_WORDS)) begin
                        write_data_d = pixel_data;
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        mem_wr_en_d  = 1'b1;
                        write_addr_d = ptr_q;
                    end
                    if (cnt_q == CNT_W'(BURST_WORDS + 1)) begin
                        ptr_d   = ptr_q + ADDR_W'(PTR_STEP);
                        word_d  = word_q + WORD_W'(BURST_WORDS);
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q < CNT_W'(CMD_GAP + 1)) begin
                    write_rq_d = 1'b1;
                end else if (cnt_q == CNT_W'(CMD_GAP + 2)) begin
                    cnt_d = '0;
                    if (word_q < WORD_W'(ROW_WORDS)) begin
                        write_rq_d = 1'b1;
                        state_d    = ST_REQ;
                    end else begin
                        state_d = ST_ROW_END;
                    end
                end
            end
            ST_ROW_END: begin
                read_rdy_d = 1'b1;
                half_d     = ~half_q;
                row_d      = row_q + ROW_W'(1);
                state_d    = ST_WAIT_CMD;
            end
            ST_DONE: begin
                upload_done_d = 1'b1;
                state_d       = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame base and PSRAM address pointer; rows are contiguous so the pointer just advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            ptr_q  <= '0;
        end else begin
            base_q <= base_d;
            ptr_q  <= ptr_d;
        end
    end

    // Row, word and burst-cycle counters plus the active row-RAM half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            row_q  <= '0;
            half_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            row_q  <= row_d;
            half_q <= half_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_rdy_q    <= 1'b0;
            pixel_addr_q  <= '0;
            write_rq_q    <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            write_addr_q  <= '0;
            write_data_q  <= '0;
            upload_done_q <= 1'b0;
        end else begin
            read_rdy_q    <= read_rdy_d;
            pixel_addr_q  <= pixel_addr_d;
            write_rq_q    <= write_rq_d;
            mem_wr_en_q   <= mem_wr_en_d;
            write_addr_q  <= write_addr_d;
            write_data_q  <= write_data_d;
            upload_done_q <= upload_done_d;
        end
    end

    assign mem_load_clk = clk;
    assign read_rdy     = read_rdy_q;
    assign pixel_addr   = pixel_addr_q;
    assign write_rq     = write_rq_q;
    assign mem_wr_en    = mem_wr_en_q;
    assign write_addr   = write_addr_q;
    assign write_data   = write_data_q;
    assign upload_done  = upload_done_q;

    // A granted burst always runs to completion; losing the grant mid-burst is an arbiter fault.
    ack_held_a: assert property (@(posedge clk) disable iff (!rst_n)
        (write_rq_q && (state_q inside {ST_PREFETCH, ST_BURST, ST_GAP})) |-> write_ack)
        else $error("frame_burst_writer: write_ack dropped during a granted burst");

endmodule

// File: tb/tb_frame_burst_writer.sv
// Bench for frame_burst_writer: random row-RAM contents, bases and NOP mixes; expected bursts
// are derived from frame geometry (base + row*width + burst*step, alternating RAM halves).
module tb_frame_burst_writer;
    import camera_mem_pkg::*;

    localparam int unsigned FW  = 64;
    localparam int unsigned FH  = 4;
    localparam int unsigned MB  = 32;
    localparam int unsigned GAP = 16;
    localparam int unsigned BW  = MB / 4;
    localparam int unsigned BURSTS_PER_ROW = (FW / 2) / BW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [20:0] base_addr;
    logic        command_data_valid;
    logic [1:0]  command_data;
    logic        read_rdy;
    logic        mem_load_clk;
    logic [9:0]  pixel_addr;
    logic [31:0] pixel_data;
    logic        write_rq;
    logic        write_ack;
    logic        mem_wr_en;
    logic [20:0] write_addr;
    logic [31:0] write_data;
    logic        upload_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ram [1024];
    logic [1:0]  cmd_mem [64];
    logic [31:0] wr_ptr = 32'd0;
    logic [31:0] rd_ptr = 32'd0;

    logic [20:0] exp_addr [$];
    int          exp_word [$];
    int pops = 0, dones = 0, bursts = 0;
    int cap_left = 0, cap_idx = 0, cur_word = 0;

    frame_burst_writer #(
        .FRAME_WIDTH (FW),
        .FRAME_HEIGHT(FH),
        .MEMORY_BURST(MB),
        .CMD_GAP     (GAP)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .base_addr         (base_addr),
        .command_data_valid(command_data_valid),
        .command_data      (command_data),
        .read_rdy          (read_rdy),
        .mem_load_clk      (mem_load_clk),
        .pixel_addr        (pixel_addr),
        .pixel_data        (pixel_data),
        .write_rq          (write_rq),
        .write_ack         (write_ack),
        .mem_wr_en         (mem_wr_en),
        .write_addr        (write_addr),
        .write_data        (write_data),
        .upload_done       (upload_done)
    );

    always #5 clk = ~clk;

    // Synchronous row RAM and load command FIFO environment.
    always @(posedge clk) pixel_data <= ram[pixel_addr];

    assign command_data_valid = (rd_ptr != wr_ptr);
    assign command_data       = cmd_mem[rd_ptr[5:0]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_ptr <= wr_ptr;
        else if (read_rdy) rd_ptr <= rd_ptr + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Scoreboard: each mem_wr_en must match the next expected burst, word by word.
    always @(negedge clk) begin
        if (!rst_n) begin
            cap_left = 0;
        end else begin
            if (read_rdy) pops++;
            if (upload_done) dones++;
            if (mem_wr_en) begin
                bursts++;
                check("burst_overlap", 32'(cap_left), 32'd0);
                if (exp_addr.size() == 0) begin
                    check("unexpected_burst", 32'(write_addr), 32'hFFFF_FFFF);
                end else begin
                    check("burst_addr", 32'(write_addr), 32'(exp_addr[0]));
                    cur_word = exp_word[0];
                    void'(exp_addr.pop_front());
                    void'(exp_word.pop_front());
                    cap_left = BW;
                    cap_idx  = 0;
                end
            end
            if (cap_left > 0) begin
                check("burst_data", write_data, ram[cur_word + cap_idx]);
                cap_idx++;
                cap_left--;
            end
        end
    end

    task automatic push_cmd(input load_cmd_e c);
        cmd_mem[wr_ptr[5:0]] = c;
        wr_ptr = wr_ptr + 32'd1;
    endtask

    // Queue one frame's commands and the bursts it should produce; returns the expected pop count.
    task automatic queue_frame(input logic [20:0] base, input int rows, input int max_nops,
                               output int n_pops);
        int nn;
        n_pops = 2;
        push_cmd(CMD_FRAME_START);
        for (int r = 0; r < rows; r++) begin
            nn = (max_nops == 0) ? 0 : int'($urandom_range(max_nops, 1));
            for (int k = 0; k < nn; k++) push_cmd(CMD_NOP);
            push_cmd(CMD_ROW_READY);
            n_pops += nn + 1;
        end
        push_cmd(CMD_FRAME_END);
        for (int r = 0; r < rows && r < int'(FH); r++) begin
            for (int b = 0; b < int'(BURSTS_PER_ROW); b++) begin
                exp_addr.push_back(21'(32'(base) + r * FW + b * (MB / 2)));
                exp_word.push_back((r % 2) * 512 + b * BW);
            end
        end
    endtask

    task automatic pulse_start(input logic [20:0] base);
        @(negedge clk);
        base_addr = base;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        base_addr = 21'($urandom);
    endtask

    task automatic finish_frame(input string name, input int pops0, input int bursts0,
                                input int dones0, input int exp_pops, input int exp_bursts);
        int t;
        t = 0;
        while (dones == dones0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("%s_done_in_time", name), 32'(t < 4000), 32'd1);
        repeat (4) @(negedge clk);
        check($sformatf("%s_bursts", name), 32'(bursts - bursts0), 32'(exp_bursts));
        check($sformatf("%s_pops", name), 32'(pops - pops0), 32'(exp_pops));
        check($sformatf("%s_done_pulses", name), 32'(dones - dones0), 32'd1);
        check($sformatf("%s_exp_drained", name), 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check($sformatf("%s_read_rdy", name), 32'(read_rdy), 32'd0);
        check($sformatf("%s_pixel_addr", name), 32'(pixel_addr), 32'd0);
        check($sformatf("%s_write_rq", name), 32'(write_rq), 32'd0);
        check($sformatf("%s_mem_wr_en", name), 32'(mem_wr_en), 32'd0);
        check($sformatf("%s_write_addr", name), 32'(write_addr), 32'd0);
        check($sformatf("%s_write_data", name), write_data, 32'd0);
        check($sformatf("%s_upload_done", name), 32'(upload_done), 32'd0);
    endtask

    initial begin
        int np, p0, b0, d0, t, lat, g;
        logic [20:0] b;
        logic [9:0]  pa;
        bit moved, wr_seen;

        rst_n     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        write_ack = 1'b1;
        for (int i = 0; i < 1024; i++) ram[i] = $urandom;
        #3 rst_n = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        check("mem_load_clk_low", 32'(mem_load_clk), 32'(clk));
        @(posedge clk);
        #1 check("mem_load_clk_high", 32'(mem_load_clk), 32'(clk));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_write_rq", 32'(write_rq), 32'd0);
        check("idle_read_rdy", 32'(read_rdy), 32'd0);

        // Full frame at the nominal base, grant always present
        p0 = pops; b0 = bursts; d0 = dones;
        queue_frame(21'h4B020, 4, 0, np);
        pulse_start(21'h4B020);
        finish_frame("full", p0, b0, d0, np, 16);

        // Grant latency: hold the grant off for 20 cycles
        write_ack = 1'b0;
        b = 21'($urandom);
        p0 = pops; b0 = bursts; d0 = dones;
        queue_frame(b, 1, 0, np);
        pulse_start(b);
        t = 0;
        while (!write_rq && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("lat_rq_rise", 32'(write_rq), 32'd1);
        pa = pixel_addr; moved = 1'b0; wr_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (pixel_addr !== pa) moved = 1'b1;
            if (mem_wr_en) wr_seen = 1'b1;
        end
        check("hold_no_cmd", 32'(wr_seen), 32'd0);
        check("hold_addr_static", 32'(moved), 32'd0);
        check("hold_rq", 32'(write_rq), 32'd1);
        write_ack = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mem_wr_en && lat < 10);
        check("grant_latency", 32'(lat), 32'd3);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (write_rq && g < 40);
        check("rq_drop_after_cmd", 32'(g), 32'(GAP));
        finish_frame("lat", p0, b0, d0, np, 4);

        // Short frame whose pointer wraps past the top of the address space
        p0 = pops; b0 = bursts; d0 = dones;
        queue_frame(21'h1FFFE0, 2, 0, np);
        pulse_start(21'h1FFFE0);
        finish_frame("short_wrap", p0, b0, d0, np, 8);

        // One row more than the frame height: last ROW_READY is popped without writes
        b = 21'($urandom);
        p0 = pops; b0 = bursts; d0 = dones;
        queue_frame(b, 5, 0, np);
        pulse_start(b);
        finish_frame("overflow", p0, b0, d0, np, 16);

        // NOPs interleaved, and a second start mid-frame that must be ignored
        b = 21'($urandom);
        p0 = pops; b0 = bursts; d0 = dones;
        queue_frame(b, 2, 3, np);
        pulse_start(b);
        repeat (40) @(negedge clk);
        pulse_start(b ^ 21'h0F0F0);
        finish_frame("nop_busy", p0, b0, d0, np, 8);

        // Reset in the middle of a burst
        b = 21'($urandom);
        p0 = pops; b0 = bursts; d0 = dones;
        queue_frame(b, 2, 0, np);
        pulse_start(b);
        t = 0;
        while (!mem_wr_en && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("abort_burst_started", 32'(mem_wr_en), 32'd1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("abort");
        exp_addr.delete();
        exp_word.delete();
        repeat (2) @(negedge clk);
        check("abort_no_done", 32'(dones - d0), 32'd0);
        rst_n = 1'b1;

        b = 21'($urandom);
        p0 = pops; b0 = bursts; d0 = dones;
        queue_frame(b, 3, 1, np);
        repeat (3) @(negedge clk);
        check("post_rst_idle_no_pop", 32'(pops - p0), 32'd0);
        pulse_start(b);
        finish_frame("post_rst", p0, b0, d0, np, 12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
